// File: rtl/fixed_mul_booth4_pipe.sv
// Radix-4 Booth pipelined multiplier with round/saturate output, sideband tag and
// a single global stall enable shared by every stage.
module fixed_mul_booth4_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int FRAC      = 0,
  parameter int OUT_WIDTH = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [A_WIDTH-1:0]   din_a,
  input  logic [B_WIDTH-1:0]   din_b,
  input  logic                 din_signed,
  input  logic [TAG_WIDTH-1:0] din_tag,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_sat,
  output logic [TAG_WIDTH-1:0] dout_tag,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int D   = B_WIDTH / 2 + 1;
  localparam int AX  = A_WIDTH + 2;
  localparam int BZ  = B_WIDTH + 3;
  localparam int HW  = A_WIDTH + 4;
  localparam int LW  = 2 * D;
  localparam int PW  = HW + LW;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [PW-1:0] RND  = (FRAC > 0) ? (PW'(1) << RSH) : PW'(0);
  localparam logic signed [PW-1:0] SMAX = (PW'(1) << (OUT_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN = -(PW'(1) << (OUT_WIDTH - 1));
  localparam logic signed [PW-1:0] UMAX = (PW'(1) << OUT_WIDTH) - PW'(1);

  function automatic logic signed [HW-1:0] booth_pp(input logic signed [AX-1:0] a,
                                                    input logic [2:0] dig);
    logic signed [HW-1:0] ax;
    ax = HW'(a);
    case (dig)
      3'b001, 3'b010: return ax;
      3'b011:         return ax <<< 1;
      3'b100:         return -(ax <<< 1);
      3'b101, 3'b110: return -ax;
      default:        return '0;
    endcase
  endfunction

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = p + RND;
    return t >>> FRAC;
  endfunction

  // Returns {sat, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [PW-1:0] r,
                                                  input logic sgn);
    if (sgn) begin
      if (r > SMAX)      return {1'b1, SMAX[OUT_WIDTH-1:0]};
      else if (r < SMIN) return {1'b1, SMIN[OUT_WIDTH-1:0]};
      else               return {1'b0, r[OUT_WIDTH-1:0]};
    end else begin
      if (r[PW-1])       return {1'b1, {OUT_WIDTH{1'b0}}};
      else if (r > UMAX) return {1'b1, UMAX[OUT_WIDTH-1:0]};
      else               return {1'b0, r[OUT_WIDTH-1:0]};
    end
  endfunction

  logic en;
  assign en        = !(dout_valid && !dout_ready);
  assign din_ready = en;

  // Index 0 is the operand capture stage; index k+1 holds the result of digit k.
  logic signed [HW-1:0]  acc_p [D+1];
  logic [LW-1:0]         lo_p  [D+1];
  logic [TAG_WIDTH-1:0]  tag_p [D+1];
  logic [D:0]            sgn_p;
  logic [D:0]            vld_p;
  logic signed [AX-1:0]  a_p   [D];
  logic [BZ-1:0]         bz_p  [D];

  logic signed [HW-1:0]  acc_nx [D];
  logic [LW-1:0]         lo_nx  [D];

  // Digit stages: add the partial product, retire two LSBs into the low shift register.
  always_comb begin
    logic signed [HW-1:0] t;
    t = '0;
    for (int k = 0; k < D; k++) begin
      t         = acc_p[k] + booth_pp(a_p[k], bz_p[k][2*k +: 3]);
      acc_nx[k] = t >>> 2;
      lo_nx[k]  = {t[1:0], lo_p[k][LW-1:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a_p[0]   <= din_signed ? {{2{din_a[A_WIDTH-1]}}, din_a} : {2'b00, din_a};
      bz_p[0]  <= {(din_signed ? {2{din_b[B_WIDTH-1]}} : 2'b00), din_b, 1'b0};
      acc_p[0] <= '0;
      lo_p[0]  <= '0;
      tag_p[0] <= din_tag;
      sgn_p    <= {sgn_p[D-1:0], din_signed};
      for (int k = 0; k < D; k++) begin
        acc_p[k+1] <= acc_nx[k];
        lo_p[k+1]  <= lo_nx[k];
        tag_p[k+1] <= tag_p[k];
      end
      for (int k = 0; k < D - 1; k++) begin
        a_p[k+1]  <= a_p[k];
        bz_p[k+1] <= bz_p[k];
      end
    end
  end

  // Output stage: exact product, round half up, clip to the output range.
  logic signed [PW-1:0] p_fin;
  logic signed [PW-1:0] r_fin;
  logic [OUT_WIDTH:0]   s_fin;

  always_comb begin
    p_fin = {acc_p[D], lo_p[D]};
    r_fin = round_shift(p_fin);
    s_fin = saturate(r_fin, sgn_p[D]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p      <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sat   <= 1'b0;
      dout_tag   <= '0;
    end else if (en) begin
      vld_p      <= {vld_p[D-1:0], din_valid};
      dout_valid <= vld_p[D];
      dout       <= s_fin[OUT_WIDTH-1:0];
      dout_sat   <= s_fin[OUT_WIDTH];
      dout_tag   <= tag_p[D];
    end
  end

endmodule

// File: tb/tb_fixed_mul_booth4_pipe.sv
// Scoreboard bench for fixed_mul_booth4_pipe: four configurations run in lockstep
// against an integer-arithmetic reference model.
module tb_fixed_mul_booth4_pipe;

  localparam int L = 10;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] din_a, din_b;
  logic        din_signed;
  logic [3:0]  din_tag;
  logic        din_valid;
  logic        dout_ready;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        dv0, dv1, dv2, dv3;
  logic        st0, st1, st2, st3;
  logic [3:0]  tg0, tg1, tg2, tg3;
  logic [31:0] d0, d2;
  logic [15:0] d1;
  logic [7:0]  d3;

  logic [3:0][32:0] got;
  logic [3:0][3:0]  tg;
  logic [3:0]       dv, rdy;

  assign got = {{st3, 24'h0, d3}, {st2, d2}, {st1, 16'h0, d1}, {st0, d0}};
  assign tg  = {tg3, tg2, tg1, tg0};
  assign dv  = {dv3, dv2, dv1, dv0};
  assign rdy = {rdy3, rdy2, rdy1, rdy0};

  always #5 clk = ~clk;

  fixed_mul_booth4_pipe u0 (
    .clk(clk), .nrst(nrst), .din_a(din_a), .din_b(din_b), .din_signed(din_signed),
    .din_tag(din_tag), .din_valid(din_valid), .din_ready(rdy0), .dout(d0),
    .dout_sat(st0), .dout_tag(tg0), .dout_valid(dv0), .dout_ready(dout_ready));

  fixed_mul_booth4_pipe #(.FRAC(8), .OUT_WIDTH(16)) u1 (
    .clk(clk), .nrst(nrst), .din_a(din_a), .din_b(din_b), .din_signed(din_signed),
    .din_tag(din_tag), .din_valid(din_valid), .din_ready(rdy1), .dout(d1),
    .dout_sat(st1), .dout_tag(tg1), .dout_valid(dv1), .dout_ready(dout_ready));

  fixed_mul_booth4_pipe #(.FRAC(1), .OUT_WIDTH(32)) u2 (
    .clk(clk), .nrst(nrst), .din_a(din_a), .din_b(din_b), .din_signed(din_signed),
    .din_tag(din_tag), .din_valid(din_valid), .din_ready(rdy2), .dout(d2),
    .dout_sat(st2), .dout_tag(tg2), .dout_valid(dv2), .dout_ready(dout_ready));

  fixed_mul_booth4_pipe #(.FRAC(4), .OUT_WIDTH(8)) u3 (
    .clk(clk), .nrst(nrst), .din_a(din_a), .din_b(din_b), .din_signed(din_signed),
    .din_tag(din_tag), .din_valid(din_valid), .din_ready(rdy3), .dout(d3),
    .dout_sat(st3), .dout_tag(tg3), .dout_valid(dv3), .dout_ready(dout_ready));

  typedef struct {
    logic [3:0][32:0] e;
    logic [3:0]       tag;
    int               acc;
    bit               lat;
    bit               hk;
    int               ki;
    logic [32:0]      k;
  } exp_t;

  exp_t q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          win_outs = 0;
  bit          cur_lat = 1'b0;
  bit          cur_hk = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          win = 1'b0;
  int          cur_ki = 0;
  logic [32:0] cur_k = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Plain integer model: exact product, round half up, clip; returns {sat, value}.
  function automatic logic [32:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int frac, input int ow);
    longint p, r, mx, mn, m;
    logic   sat;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    if (frac > 0) r = (p + (longint'(1) << (frac - 1))) >>> frac;
    else          r = p;
    if (s) begin
      mx = (longint'(1) << (ow - 1)) - 1;
      mn = -(longint'(1) << (ow - 1));
    end else begin
      mx = (longint'(1) << ow) - 1;
      mn = 0;
    end
    sat = 1'b0;
    if (r > mx) begin
      r = mx; sat = 1'b1;
    end else if (r < mn) begin
      r = mn; sat = 1'b1;
    end
    m = (longint'(1) << ow) - 1;
    return {sat, 32'(r & m)};
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: everything sampled mid-cycle, ahead of the next rising edge.
  initial begin
    exp_t             e;
    bit               pst;
    logic [3:0][32:0] pg;
    logic [3:0][3:0]  pt;
    pst = 1'b0;
    pg  = '0;
    pt  = '0;
    forever begin
      @(negedge clk);
      if (nrst !== 1'b1) begin
        pst = 1'b0;
        continue;
      end
      check("din_ready", 160'(rdy), 160'({4{~(dv0 & ~dout_ready)}}));
      check("lockstep_valid", 160'(dv), 160'({4{dv0}}));
      if (pst) begin
        check("stall_valid", 160'(dv0), 160'(1));
        check("stall_dout", 160'(got), 160'(pg));
        check("stall_tag", 160'(tg), 160'(pt));
      end
      if (win && dv0) win_outs++;
      if (dv0 && dout_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h required no output", got);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            check($sformatf("dout_cfg%0d", i), 160'(got[i]), 160'(e.e[i]));
            check($sformatf("tag_cfg%0d", i), 160'(tg[i]), 160'(e.tag));
          end
          if (e.hk) check($sformatf("known_value_cfg%0d", e.ki), 160'(got[e.ki]), 160'(e.k));
          if (e.lat) check("latency", 160'(cyc - e.acc), 160'(L));
        end
      end
      if (din_valid && rdy0) begin
        e.e[0] = ref_mul(din_a, din_b, din_signed, 0, 32);
        e.e[1] = ref_mul(din_a, din_b, din_signed, 8, 16);
        e.e[2] = ref_mul(din_a, din_b, din_signed, 1, 32);
        e.e[3] = ref_mul(din_a, din_b, din_signed, 4, 8);
        e.tag  = din_tag;
        e.acc  = cyc + 1;
        e.lat  = cur_lat;
        e.hk   = cur_hk;
        e.ki   = cur_ki;
        e.k    = cur_k;
        q.push_back(e);
      end
      pst = dv0 && !dout_ready;
      pg  = got;
      pt  = tg;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) dout_ready = ($urandom_range(0, 99) < 30);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [3:0] t);
    int n;
    bit acc;
    n = 0;
    din_a = a; din_b = b; din_signed = s; din_tag = t; din_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      n++;
      if (n > 2000) begin
        $display("FAIL send_timeout: got no acceptance required acceptance");
        $fatal(1, "input never accepted");
      end
    end while (!acc);
  endtask

  task automatic send_k(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] t, input int ki, input logic [32:0] k);
    cur_hk = 1'b1; cur_ki = ki; cur_k = k;
    send(a, b, s, t);
    cur_hk = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 160'(q.size()), 160'(0));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    nrst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    din_a = '0; din_b = '0; din_signed = 1'b0; din_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 160'(dv), 160'(0));
    check("reset_dout", 160'(got), 160'(0));
    check("reset_tag", 160'(tg), 160'(0));
    check("reset_din_ready", 160'(rdy), 160'(4'hF));
    nrst = 1'b1;
    @(posedge clk);
    #1;

    cur_lat = 1'b1;
    send_k(16'h8000, 16'h8000, 1'b1, 4'd5,  0, {1'b0, 32'h4000_0000});
    send_k(16'hFFFF, 16'hFFFF, 1'b0, 4'd1,  0, {1'b0, 32'hFFFE_0001});
    send_k(16'hFFFF, 16'hFFFF, 1'b0, 4'd2,  3, {1'b1, 32'h0000_00FF});
    send_k(16'hFFFF, 16'hFFFF, 1'b1, 4'd3,  0, {1'b0, 32'h0000_0001});
    send_k(16'h8000, 16'h7FFF, 1'b1, 4'd4,  0, {1'b0, 32'hC000_8000});
    send_k(16'h8000, 16'h7FFF, 1'b1, 4'd6,  1, {1'b1, 32'h0000_8000});
    send_k(16'h0180, 16'h0180, 1'b1, 4'd7,  1, {1'b0, 32'h0000_0240});
    send_k(16'h7FFF, 16'h7FFF, 1'b1, 4'd8,  1, {1'b1, 32'h0000_7FFF});
    send_k(16'hFFFD, 16'h0001, 1'b1, 4'd9,  2, {1'b0, 32'hFFFF_FFFF});
    send_k(16'h0003, 16'h0001, 1'b1, 4'd10, 2, {1'b0, 32'h0000_0002});
    din_valid = 1'b0;
    drain();

    cur_lat  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++)
      send(pick(), pick(), 1'($urandom_range(0, 1)), 4'($urandom));
    din_valid = 1'b0;
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    dout_ready = 1'b1;

    cur_lat = 1'b1;
    for (int i = 0; i < 12; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'(i));
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_valid", 160'(dv0), 160'(1));
    nrst = 1'b0;
    q.delete();
    #1;
    check("reset_async_valid", 160'(dv), 160'(0));
    check("reset_async_dout", 160'(got), 160'(0));
    @(posedge clk);
    #1;
    nrst = 1'b1;
    win_outs = 0;
    win = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    win = 1'b0;
    check("post_reset_quiet", 160'(win_outs), 160'(0));
    send_k(16'h8000, 16'h8000, 1'b1, 4'd5, 0, {1'b0, 32'h4000_0000});
    din_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
